hbus_arb: RTL and testbench
===========================

# hbus_arb

Parametrised round-robin arbiter between N harts' L2 miss/writeback ports (`h_*`) and a single shared next-level memory port. It replaces the point-to-point hart-to-memory connection with a serialised, fair, multi-hart bus. On every completed write it broadcasts a line invalidation to all other harts, which keeps their private L2 copies coherent. It is instantiated once per cluster, between the hart instances and the memory controller.

## Interface

Parameters:

- `N_HARTS`, 4: number of hart ports, at least 2.
- `LINE_W`, `` `hmem_line ``: line width in bits.
- `ADDR_W`, 64: address width.

Ports (vectors are flattened; hart i occupies slice i):

- `clk`  in  1  single clock; all logic on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `h_addr`  in  N_HARTS*ADDR_W  request address per hart.
- `h_rd`  in  N_HARTS  read (refill) request, level, per hart.
- `h_wr`  in  N_HARTS  write (writeback) request, level, per hart.
- `h_data_out`  in  N_HARTS*LINE_W  write line per hart.
- `h_data_in`  out  LINE_W  read line, broadcast to all harts.
- `h_dv`  out  N_HARTS  one-cycle completion pulse per hart.
- `inv_addr`  out  ADDR_W  invalidation address, broadcast.
- `inv`  out  N_HARTS  one-cycle invalidate strobe per hart.
- `m_addr`  out  ADDR_W  memory address.
- `m_rd` / `m_wr`  out  1  memory read / write request, level.
- `m_data_out`  out  LINE_W  memory write line.
- `m_data_in`  in  LINE_W  memory read line.
- `m_dv`  in  1  memory completion, one-cycle pulse.

## Operation

- Request rules:
  - A hart holds `h_rd` or `h_wr`, together with `h_addr` and `h_data_out`, stable until it sees `h_dv[i]`.
  - The hart drops the request at the clock edge that samples `h_dv[i]`.
- FSM states are IDLE, BUSY and DONE.
- **IDLE:**
  - `req[i] = h_rd[i] | h_wr[i]`.
  - If any request is pending, grant the first requester at or after `rr_ptr`, scanning upward and wrapping modulo N_HARTS.
  - At the grant, register the grant index `g`, `m_addr <= h_addr[g]` and `m_data_out <= h_data_out[g]`.
  - Set `m_wr <= h_wr[g]` and `m_rd <= h_rd[g] & ~h_wr[g]`. If a hart raises both, its write is serviced first; its read is then re-arbitrated as a new request.
  - Go to BUSY.
- **BUSY:**
  - Hold `m_*` stable until `m_dv` is sampled high.
  - On that edge, drop `m_rd`/`m_wr`, latch `h_data_in <= m_data_in` (read only; unchanged on a write), set `h_dv[g]`, and go to DONE.
  - If the op was a write, also set `inv_addr <= m_addr` and `inv <= ~onehot(g)`.
- **DONE:**
  - `h_dv` and `inv` are high for exactly this cycle.
  - Set `rr_ptr <= (g+1) mod N_HARTS` and go to IDLE.
  - `h_dv` and `inv` clear on the next edge.
- Pointer wrap: when `g = N_HARTS-1`, `rr_ptr` wraps to 0.
- Fairness: a continuously requesting hart waits at most N_HARTS-1 other transactions.
- `h_data_in` holds its last value between reads. Only the hart whose `h_dv` bit is set may consume it.
- Exactly one memory transaction is outstanding at a time. `m_rd` and `m_wr` are never high together.
- `m_dv` is ignored outside BUSY.
- New requests arriving during BUSY or DONE wait for the next IDLE.

## Timing

- Reset, synchronous and taking priority over everything:
  - state <= IDLE, `rr_ptr` <= 0.
  - `m_rd`, `m_wr`, `h_dv`, `inv` <= 0.
  - `m_addr`, `m_data_out`, `inv_addr`, `h_data_in` <= 0.
- Reset asserted during BUSY abandons the memory op: `m_rd`/`m_wr` are low from the next cycle and no `h_dv` is produced.
- Latency, with the request first sampled in IDLE at edge 0:
  - `m_*` valid in cycle 1.
  - `m_dv` earliest in cycle 1, giving `h_dv`/`inv` in cycle 2.
  - IDLE in cycle 3; next grant at edge 3, with `m_*` in cycle 4.
- Minimum request-to-`h_dv` latency is 2 cycles plus memory latency. Minimum spacing between back-to-back memory ops is 3 cycles.

## Test plan

- Single read:
  - Stimulus: hart 0, `h_rd`, addr 0x1000; memory returns `m_dv` 3 cycles after `m_rd`, data pattern 0xA5...
  - Required: `m_rd`/`m_addr`=0x1000 at cycle 1; `h_dv`=4'b0001 one cycle after `m_dv`; `h_data_in`=pattern; `inv`=0.
- Simultaneous requests:
  - Stimulus: harts 0 and 2 request in the same cycle after reset.
  - Required: hart 0 is served first, then hart 2; `rr_ptr` = 3 afterwards.
- Round-robin fairness:
  - Stimulus: all 4 harts request continuously for 12 transactions.
  - Required: grant order 0,1,2,3,0,1,2,3,...; no hart is ever skipped.
- Write invalidation:
  - Stimulus: hart 1 `h_wr` at addr 0x2040 with a line pattern.
  - Required: `m_wr` high with `m_data_out` = pattern; in the `h_dv`=4'b0010 cycle, `inv`=4'b1101 and `inv_addr`=0x2040, each for one cycle.
- Read and write from the same hart:
  - Stimulus: hart 3 raises `h_rd` and `h_wr` together.
  - Required: the write completes first (`m_wr`, `inv`=4'b0111); the read is then re-arbitrated.
- Reset mid-transaction:
  - Stimulus: `rst_n` pulled low in BUSY before `m_dv`.
  - Required: all outputs are 0 the next cycle; a later `m_dv` produces no `h_dv`; after reset the first grant goes to the lowest-index requester.

Source files
------------

// File: rtl/hbus_arb.sv
// hbus_arb: fair round-robin arbiter serialising N harts' L2 miss/writeback
// ports onto one next-level memory port, with invalidation broadcast on writes.
`ifndef HMEM_LINE
`define HMEM_LINE 512
`endif

module hbus_arb #(
  parameter int N_HARTS = 4,
  parameter int LINE_W  = `HMEM_LINE,
  parameter int ADDR_W  = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_HARTS*ADDR_W-1:0] h_addr,
  input  logic [N_HARTS-1:0]        h_rd,
  input  logic [N_HARTS-1:0]        h_wr,
  input  logic [N_HARTS*LINE_W-1:0] h_data_out,
  output logic [LINE_W-1:0]         h_data_in,
  output logic [N_HARTS-1:0]        h_dv,
  output logic [ADDR_W-1:0]         inv_addr,
  output logic [N_HARTS-1:0]        inv,
  output logic [ADDR_W-1:0]         m_addr,
  output logic                      m_rd,
  output logic                      m_wr,
  output logic [LINE_W-1:0]         m_data_out,
  input  logic [LINE_W-1:0]         m_data_in,
  input  logic                      m_dv
);

  localparam int IDX_W = (N_HARTS > 1) ? $clog2(N_HARTS) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]         state;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   g;
  logic [N_HARTS-1:0] req;
  logic               found;
  logic [IDX_W-1:0]   pick;
  logic [N_HARTS-1:0] g_onehot;
  logic [IDX_W-1:0]   next_ptr;

  // Index base+off modulo N_HARTS; both operands are below N_HARTS, so one
  // conditional subtract is enough even for non-power-of-two hart counts.
  function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= N_HARTS) sum = sum - N_HARTS;
    return IDX_W'(sum);
  endfunction

  assign req      = h_rd | h_wr;
  assign g_onehot = N_HARTS'(1) << g;
  assign next_ptr = (g == IDX_W'(N_HARTS - 1)) ? '0 : g + IDX_W'(1);

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    found = 1'b0;
    pick  = '0;
    for (int k = 0; k < N_HARTS; k++) begin
      if (!found && req[wrap_idx(rr_ptr, k)]) begin
        found = 1'b1;
        pick  = wrap_idx(rr_ptr, k);
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking (<=) so all of them sample pre-edge values.
    if (!rst_n) begin
      state      <= S_IDLE;
      rr_ptr     <= '0;
      g          <= '0;
      m_rd       <= 1'b0;
      m_wr       <= 1'b0;
      h_dv       <= '0;
      inv        <= '0;
      m_addr     <= '0;
      m_data_out <= '0;
      inv_addr   <= '0;
      h_data_in  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (found) begin
            g          <= pick;
            m_addr     <= h_addr[pick*ADDR_W +: ADDR_W];
            m_data_out <= h_data_out[pick*LINE_W +: LINE_W];
            // A hart raising both is served write-first; its read stays pending.
            m_wr       <= h_wr[pick];
            m_rd       <= h_rd[pick] & ~h_wr[pick];
            state      <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (m_dv) begin
            m_rd  <= 1'b0;
            m_wr  <= 1'b0;
            h_dv  <= g_onehot;
            if (m_wr) begin
              inv_addr <= m_addr;
              inv      <= ~g_onehot;
            end else begin
              h_data_in <= m_data_in;
            end
            state <= S_DONE;
          end
        end
        S_DONE: begin
          h_dv   <= '0;
          inv    <= '0;
          rr_ptr <= next_ptr;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hbus_arb.sv
// Self-checking bench for hbus_arb: directed latency checks plus randomized
// rounds compared against a round-robin service-order model.
module tb_hbus_arb;

  localparam int N  = 4;
  localparam int AW = 64;
  localparam int LW = 128;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [N*AW-1:0] h_addr;
  logic [N-1:0]    h_rd, h_wr;
  logic [N*LW-1:0] h_data_out;
  logic [LW-1:0]   h_data_in;
  logic [N-1:0]    h_dv, inv;
  logic [AW-1:0]   inv_addr, m_addr;
  logic            m_rd, m_wr, m_dv;
  logic [LW-1:0]   m_data_out, m_data_in;

  hbus_arb #(.N_HARTS(N), .LINE_W(LW), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .h_addr(h_addr), .h_rd(h_rd), .h_wr(h_wr),
    .h_data_out(h_data_out), .h_data_in(h_data_in), .h_dv(h_dv),
    .inv_addr(inv_addr), .inv(inv), .m_addr(m_addr), .m_rd(m_rd), .m_wr(m_wr),
    .m_data_out(m_data_out), .m_data_in(m_data_in), .m_dv(m_dv)
  );

  // Hart request registers, owned by the hart driver process.
  logic [AW-1:0] hr_addr [N];
  logic [LW-1:0] hr_data [N];
  logic [N-1:0]  hr_rd, hr_wr;
  int            ld_seq [N];

  for (genvar i = 0; i < N; i++) begin : g_pack
    assign h_addr[i*AW +: AW]     = hr_addr[i];
    assign h_data_out[i*LW +: LW] = hr_data[i];
  end
  assign h_rd = hr_rd;
  assign h_wr = hr_wr;

  // Staging written by the main thread, picked up by the hart driver.
  bit            st_rd [N], st_wr [N];
  logic [AW-1:0] st_addr [N];
  logic [LW-1:0] st_data [N];
  int            st_seq [N];

  // Current-round request record used by the reference model.
  bit            r_rd [N], r_wr [N];
  logic [AW-1:0] r_addr [N];
  logic [LW-1:0] r_data [N];

  int mem_lat;
  int inj_seq, inj_done;

  int pass_cnt, total_cnt;
  int model_ptr;
  logic [LW-1:0] model_mem [logic [AW-1:0]];
  logic [LW-1:0] model_last_rd;

  typedef struct {
    logic [N-1:0]  dv;
    logic          was_rd;
    logic          was_wr;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
    logic [LW-1:0] rdata;
    logic [N-1:0]  inv;
    logic [AW-1:0] inv_addr;
  } obs_t;

  obs_t obs_q [$];
  int   obs_rd;
  int   viol;

  typedef struct {
    int            g;
    bit            wr;
    logic [AW-1:0] addr;
    logic [LW-1:0] data;
    logic [LW-1:0] prev_rd;
  } exp_t;

  function automatic logic [LW-1:0] dflt_line(input logic [AW-1:0] a);
    return {a * 64'h9E37_79B9_7F4A_7C15, a ^ 64'hA5A5_5A5A_0F0F_F0F0};
  endfunction

  function automatic logic [LW-1:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [LW-1:0] model_read(input logic [AW-1:0] a);
    if (model_mem.exists(a)) return model_mem[a];
    return dflt_line(a);
  endfunction

  // Hart driver: drops a request on seeing its h_dv (write first when both
  // are held), and loads newly staged requests once the hart is idle.
  initial begin
    hr_rd = '0;
    hr_wr = '0;
    for (int i = 0; i < N; i++) begin
      hr_addr[i] = '0;
      hr_data[i] = '0;
      ld_seq[i]  = 0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (h_dv[i] === 1'b1) begin
          if (hr_wr[i]) hr_wr[i] = 1'b0;
          else hr_rd[i] = 1'b0;
        end else if (ld_seq[i] != st_seq[i] && !hr_rd[i] && !hr_wr[i]) begin
          hr_rd[i]   = st_rd[i];
          hr_wr[i]   = st_wr[i];
          hr_addr[i] = st_addr[i];
          hr_data[i] = st_data[i];
          ld_seq[i]  = st_seq[i];
        end
      end
    end
  end

  // Memory responder with programmable latency and its own line store.
  initial begin
    logic [LW-1:0] mem_store [logic [AW-1:0]];
    int wait_cnt;
    m_dv      = 1'b0;
    m_data_in = '0;
    wait_cnt  = 0;
    inj_done  = 0;
    mem_store[64'h1000] = {(LW/8){8'hA5}};
    forever begin
      @(negedge clk);
      if (m_dv) begin
        m_dv = 1'b0;
      end else if (inj_done != inj_seq) begin
        inj_done  = inj_seq;
        m_dv      = 1'b1;
        m_data_in = {(LW/32){32'hDEAD_BEEF}};
      end else if (m_rd === 1'b1 || m_wr === 1'b1) begin
        if (wait_cnt >= mem_lat) begin
          wait_cnt = 0;
          m_dv     = 1'b1;
          if (m_wr) begin
            mem_store[m_addr] = m_data_out;
            m_data_in = ~m_data_out;
          end else if (mem_store.exists(m_addr)) begin
            m_data_in = mem_store[m_addr];
          end else begin
            m_data_in = dflt_line(m_addr);
          end
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Completion monitor plus protocol watch.
  initial begin
    logic lrd, lwr;
    logic [N-1:0] prev_dv;
    obs_t r;
    viol    = 0;
    lrd     = 1'b0;
    lwr     = 1'b0;
    prev_dv = '0;
    forever begin
      @(negedge clk);
      if (m_rd === 1'b1 && m_wr === 1'b1) viol++;
      if (m_rd === 1'b1 || m_wr === 1'b1) begin
        lrd = m_rd;
        lwr = m_wr;
      end
      if ($countones(h_dv) > 1) viol++;
      if ((h_dv & prev_dv) != '0) viol++;
      if (inv != '0 && h_dv == '0) viol++;
      if (h_dv != '0 && !$isunknown(h_dv)) begin
        r.dv = h_dv; r.was_rd = lrd; r.was_wr = lwr; r.addr = m_addr;
        r.wdata = m_data_out; r.rdata = h_data_in; r.inv = inv; r.inv_addr = inv_addr;
        obs_q.push_back(r);
      end
      prev_dv = h_dv;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic stage(input int i, input bit rd, input bit wr,
                       input logic [AW-1:0] a, input logic [LW-1:0] d);
    st_rd[i] = rd; st_wr[i] = wr; st_addr[i] = a; st_data[i] = d;
    st_seq[i]++;
    r_rd[i] = rd; r_wr[i] = wr; r_addr[i] = a; r_data[i] = d;
  endtask

  // Predict the service order of all requests in r_*, wait for them, compare.
  task automatic run_round(input string name);
    bit   pr [N], pw [N];
    exp_t exp_q [$];
    exp_t e;
    obs_t o;
    int   g, budget;
    for (int i = 0; i < N; i++) begin
      pr[i] = r_rd[i];
      pw[i] = r_wr[i];
    end
    forever begin
      g = -1;
      for (int k = 0; k < N; k++) begin
        int c;
        c = (model_ptr + k) % N;
        if (g < 0 && (pr[c] || pw[c])) g = c;
      end
      if (g < 0) break;
      e.g = g; e.addr = r_addr[g]; e.prev_rd = model_last_rd;
      if (pw[g]) begin
        e.wr = 1'b1; e.data = r_data[g];
        model_mem[r_addr[g]] = r_data[g];
        pw[g] = 1'b0;
      end else begin
        e.wr = 1'b0; e.data = model_read(r_addr[g]);
        model_last_rd = e.data;
        pr[g] = 1'b0;
      end
      exp_q.push_back(e);
      model_ptr = (g + 1) % N;
    end
    for (int i = 0; i < N; i++) begin
      r_rd[i] = 1'b0;
      r_wr[i] = 1'b0;
    end

    budget = 40 * exp_q.size() + 20;
    while (obs_q.size() < obs_rd + exp_q.size() && budget > 0) begin
      tick(1);
      budget--;
    end
    total_cnt++;
    if (obs_q.size() < obs_rd + exp_q.size()) begin
      $display("FAIL %s timeout: got %0d completions, want %0d", name,
               obs_q.size() - obs_rd, exp_q.size());
      obs_rd = obs_q.size();
      return;
    end
    pass_cnt++;

    foreach (exp_q[t]) begin
      e = exp_q[t];
      o = obs_q[obs_rd];
      obs_rd++;
      total_cnt++;
      if (o.dv !== N'(1) << e.g)
        $display("FAIL %s tx%0d grant: got %b want %b", name, t, o.dv, N'(1) << e.g);
      else pass_cnt++;
      total_cnt++;
      if ({o.was_wr, o.was_rd} !== {e.wr, ~e.wr})
        $display("FAIL %s tx%0d op wr/rd: got %b%b want %b%b", name, t, o.was_wr, o.was_rd, e.wr, ~e.wr);
      else pass_cnt++;
      total_cnt++;
      if (o.addr !== e.addr)
        $display("FAIL %s tx%0d m_addr: got %h want %h", name, t, o.addr, e.addr);
      else pass_cnt++;
      if (e.wr) begin
        total_cnt++;
        if (o.wdata !== e.data)
          $display("FAIL %s tx%0d m_data_out: got %h want %h", name, t, o.wdata, e.data);
        else pass_cnt++;
        total_cnt++;
        if (o.inv !== ~(N'(1) << e.g) || o.inv_addr !== e.addr)
          $display("FAIL %s tx%0d inv/inv_addr: got %b/%h want %b/%h", name, t,
                   o.inv, o.inv_addr, ~(N'(1) << e.g), e.addr);
        else pass_cnt++;
        total_cnt++;
        if (o.rdata !== e.prev_rd)
          $display("FAIL %s tx%0d h_data_in kept: got %h want %h", name, t, o.rdata, e.prev_rd);
        else pass_cnt++;
      end else begin
        total_cnt++;
        if (o.rdata !== e.data)
          $display("FAIL %s tx%0d h_data_in: got %h want %h", name, t, o.rdata, e.data);
        else pass_cnt++;
        total_cnt++;
        if (o.inv !== '0)
          $display("FAIL %s tx%0d inv on read: got %b want 0", name, t, o.inv);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(3);
    total_cnt++;
    if ({m_rd, m_wr, h_dv, inv} !== '0)
      $display("FAIL reset ctrl: got m_rd=%b m_wr=%b h_dv=%b inv=%b want 0", m_rd, m_wr, h_dv, inv);
    else pass_cnt++;
    total_cnt++;
    if (m_addr !== '0 || inv_addr !== '0)
      $display("FAIL reset addr: got m_addr=%h inv_addr=%h want 0", m_addr, inv_addr);
    else pass_cnt++;
    total_cnt++;
    if (m_data_out !== '0 || h_data_in !== '0)
      $display("FAIL reset data: got m_data_out=%h h_data_in=%h want 0", m_data_out, h_data_in);
    else pass_cnt++;
    rst_n = 1'b1;
    model_ptr = 0;
    model_last_rd = '0;
    tick(2);
  endtask

  task automatic test_single_read();
    logic [LW-1:0] pat;
    int cyc;
    pat = {(LW/8){8'hA5}};
    mem_lat = 3;
    stage(0, 1'b1, 1'b0, 64'h1000, '0);
    r_rd[0] = 1'b0;
    tick(1);
    total_cnt++;
    if (m_rd !== 1'b1 || m_wr !== 1'b0 || m_addr !== 64'h1000)
      $display("FAIL single_read cycle1: got m_rd=%b m_wr=%b m_addr=%h want 1 0 1000", m_rd, m_wr, m_addr);
    else pass_cnt++;
    cyc = 1;
    while (h_dv === '0 && cyc < 20) begin
      tick(1);
      cyc++;
    end
    total_cnt++;
    if (cyc !== 5 || h_dv !== 4'b0001)
      $display("FAIL single_read h_dv: got %b in cycle %0d want 0001 in cycle 5", h_dv, cyc);
    else pass_cnt++;
    total_cnt++;
    if (h_data_in !== pat || inv !== '0 || m_rd !== 1'b0)
      $display("FAIL single_read data: got h_data_in=%h inv=%b m_rd=%b want %h 0 0", h_data_in, inv, m_rd, pat);
    else pass_cnt++;
    tick(1);
    total_cnt++;
    if (h_dv !== '0 || inv !== '0)
      $display("FAIL single_read pulse: got h_dv=%b inv=%b want 0 next cycle", h_dv, inv);
    else pass_cnt++;
    tick(2);
    obs_rd = obs_q.size();
    model_mem[64'h1000] = pat;
    model_last_rd = pat;
    model_ptr = 1;
  endtask

  task automatic test_simultaneous();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    model_ptr = 0;
    model_last_rd = '0;
    mem_lat = $urandom_range(0, 3);
    stage(2, 1'b1, 1'b0, 64'h4000 + AW'($urandom_range(0, 15) << 6), '0);
    stage(0, 1'b1, 1'b0, 64'h4400, '0);
    run_round("simultaneous");
    stage(0, 1'b1, 1'b0, 64'h4800, '0);
    stage(3, 1'b1, 1'b0, 64'h4840, '0);
    run_round("ptr_after_simul");
  endtask

  task automatic test_fairness();
    int ptr0, issued [N], g, budget;
    obs_t o;
    logic [LW-1:0] want;
    ptr0 = model_ptr;
    mem_lat = 1;
    for (int i = 0; i < N; i++) begin
      stage(i, $urandom_range(0, 1) == 0, 1'b0, 64'h8000 + AW'($urandom_range(0, 7) << 6), rand_line());
      r_wr[i] = ~r_rd[i];
      st_wr[i] = r_wr[i];
      issued[i] = 1;
    end
    for (int t = 0; t < 12; t++) begin
      budget = 60;
      while (obs_q.size() <= obs_rd && budget > 0) begin
        tick(1);
        budget--;
      end
      total_cnt++;
      if (obs_q.size() <= obs_rd) begin
        $display("FAIL fairness tx%0d timeout", t);
        break;
      end
      pass_cnt++;
      o = obs_q[obs_rd];
      obs_rd++;
      g = (ptr0 + t) % N;
      total_cnt++;
      if (o.dv !== N'(1) << g)
        $display("FAIL fairness tx%0d grant: got %b want %b", t, o.dv, N'(1) << g);
      else pass_cnt++;
      if (r_wr[g]) begin
        model_mem[r_addr[g]] = r_data[g];
        total_cnt++;
        if (o.was_wr !== 1'b1 || o.wdata !== r_data[g] || o.inv !== ~(N'(1) << g))
          $display("FAIL fairness tx%0d write: got wr=%b inv=%b want wr=1 inv=%b", t, o.was_wr, o.inv, ~(N'(1) << g));
        else pass_cnt++;
      end else begin
        want = model_read(r_addr[g]);
        model_last_rd = want;
        total_cnt++;
        if (o.was_rd !== 1'b1 || o.rdata !== want)
          $display("FAIL fairness tx%0d read: got rd=%b data=%h want 1 %h", t, o.was_rd, o.rdata, want);
        else pass_cnt++;
      end
      r_rd[g] = 1'b0;
      r_wr[g] = 1'b0;
      if (issued[g] < 3) begin
        issued[g]++;
        stage(g, $urandom_range(0, 1) == 0, 1'b0, 64'h8000 + AW'($urandom_range(0, 7) << 6), rand_line());
        r_wr[g] = ~r_rd[g];
        st_wr[g] = r_wr[g];
      end
      mem_lat = $urandom_range(0, 3);
    end
    model_ptr = (ptr0 + 12) % N;
    tick(4);
  endtask

  task automatic test_write_inv();
    logic [LW-1:0] pat;
    int cyc;
    pat = rand_line();
    mem_lat = 2;
    stage(1, 1'b0, 1'b1, 64'h2040, pat);
    r_wr[1] = 1'b0;
    tick(1);
    total_cnt++;
    if (m_wr !== 1'b1 || m_rd !== 1'b0 || m_addr !== 64'h2040 || m_data_out !== pat)
      $display("FAIL write_inv mem: got m_wr=%b m_rd=%b m_addr=%h m_data_out=%h", m_wr, m_rd, m_addr, m_data_out);
    else pass_cnt++;
    cyc = 1;
    while (h_dv === '0 && cyc < 20) begin
      tick(1);
      cyc++;
    end
    total_cnt++;
    if (h_dv !== 4'b0010 || inv !== 4'b1101 || inv_addr !== 64'h2040)
      $display("FAIL write_inv strobe: got h_dv=%b inv=%b inv_addr=%h want 0010 1101 2040", h_dv, inv, inv_addr);
    else pass_cnt++;
    total_cnt++;
    if (h_data_in !== model_last_rd)
      $display("FAIL write_inv h_data_in kept: got %h want %h", h_data_in, model_last_rd);
    else pass_cnt++;
    tick(1);
    total_cnt++;
    if (h_dv !== '0 || inv !== '0)
      $display("FAIL write_inv pulse: got h_dv=%b inv=%b want 0", h_dv, inv);
    else pass_cnt++;
    tick(2);
    obs_rd = obs_q.size();
    model_mem[64'h2040] = pat;
    model_ptr = 2;
  endtask

  task automatic test_rd_wr_same();
    mem_lat = 1;
    stage(3, 1'b1, 1'b1, 64'h2080, rand_line());
    run_round("rd_wr_same");
  endtask

  task automatic test_random();
    int op;
    for (int rnd = 0; rnd < 6; rnd++) begin
      logic [N-1:0] mask;
      mask = N'($urandom_range(1, (1 << N) - 1));
      mem_lat = $urandom_range(0, 4);
      for (int i = 0; i < N; i++) begin
        if (mask[i]) begin
          op = $urandom_range(0, 2);
          stage(i, op != 1, op != 0, 64'h8000 + AW'($urandom_range(0, 7) << 6), rand_line());
        end
      end
      run_round("random");
      tick($urandom_range(0, 3));
    end
  endtask

  task automatic test_reset_midop();
    int budget;
    mem_lat = 20;
    stage(2, 1'b1, 1'b0, 64'h3000, '0);
    budget = 10;
    while (m_rd !== 1'b1 && budget > 0) begin
      tick(1);
      budget--;
    end
    total_cnt++;
    if (m_rd !== 1'b1)
      $display("FAIL reset_midop busy: got m_rd=%b want 1", m_rd);
    else pass_cnt++;
    tick(2);
    rst_n = 1'b0;
    tick(1);
    total_cnt++;
    if ({m_rd, m_wr, h_dv, inv} !== '0 || m_addr !== '0 || inv_addr !== '0 ||
        h_data_in !== '0 || m_data_out !== '0)
      $display("FAIL reset_midop outputs: got m_rd=%b m_wr=%b h_dv=%b inv=%b m_addr=%h h_data_in=%h",
               m_rd, m_wr, h_dv, inv, m_addr, h_data_in);
    else pass_cnt++;
    inj_seq++;
    stage(3, 1'b0, 1'b1, 64'h3080, rand_line());
    stage(1, 1'b1, 1'b0, 64'h3040, '0);
    tick(3);
    total_cnt++;
    if (h_dv !== '0 || obs_q.size() != obs_rd)
      $display("FAIL reset_midop late m_dv: got h_dv=%b extra completions=%0d want none", h_dv, obs_q.size() - obs_rd);
    else pass_cnt++;
    model_ptr = 0;
    model_last_rd = '0;
    mem_lat = 1;
    rst_n = 1'b1;
    run_round("after_reset");
  endtask

  task automatic test_idle_dv();
    tick(3);
    inj_seq++;
    tick(5);
    total_cnt++;
    if (h_dv !== '0 || obs_q.size() != obs_rd || m_rd !== 1'b0 || m_wr !== 1'b0)
      $display("FAIL idle_dv: got h_dv=%b m_rd=%b m_wr=%b extra=%0d want idle", h_dv, m_rd, m_wr, obs_q.size() - obs_rd);
    else pass_cnt++;
    total_cnt++;
    if (viol != 0)
      $display("FAIL protocol: got %0d violations want 0", viol);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt = 0;
    total_cnt = 0;
    obs_rd = 0;
    inj_seq = 0;
    mem_lat = 1;
    model_ptr = 0;
    model_last_rd = '0;
    for (int i = 0; i < N; i++) begin
      st_seq[i] = 0; st_rd[i] = 1'b0; st_wr[i] = 1'b0; st_addr[i] = '0; st_data[i] = '0;
      r_rd[i] = 1'b0; r_wr[i] = 1'b0; r_addr[i] = '0; r_data[i] = '0;
    end
    model_mem[64'h1000] = {(LW/8){8'hA5}};
    rst_n = 1'b0;
    tick(1);
    test_reset();
    test_single_read();
    test_simultaneous();
    test_fairness();
    test_write_inv();
    test_rd_wr_same();
    test_random();
    test_reset_midop();
    test_idle_dv();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
